wb_sram_slave: RTL and testbench

//  Wishbone B4 classic slave with on-chip synchronous SRAM. Sits directly downstream of the
//  CPU bus master and consumes its CYC/STB/WE/SEL/ADR/DAT cycle, returning ACK and read data.
//  The master supplies byte/half data right-aligned in lane 0 with SEL 0001/0011/1111. This block

---
 rtl/wb_sram_slave_if.sv | 31 +++
 rtl/wb_sram_slave.sv | 162 ++++++++++++++++
 tb/tb_wb_sram_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 classic bus bundle for wb_sram_slave.
// ERR_O is present only when WB_SRAM_ERR_EN is defined.
interface wb_sram_slave_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [3:0]  SEL_I;
   logic [31:0] ADR_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;
`ifdef WB_SRAM_ERR_EN
   logic        ERR_O;
`endif

   modport master (
      output CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O
`ifdef WB_SRAM_ERR_EN
      , input ERR_O
`endif
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I,
      output DAT_O, ACK_O
`ifdef WB_SRAM_ERR_EN
      , output ERR_O
`endif
   );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave over on-chip SRAM with lane realignment.
// Define WB_SRAM_ERR_EN to answer misaligned/illegal SEL with ERR_O.
module wb_sram_slave #(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_STATES = 1
) (
   input logic            CLK_I,
   input logic            RST_N_I,
   wb_sram_slave_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [3:0]            sel;
      logic [1:0]            off;
      logic [ADDR_WIDTH-1:0] idx;
      logic [31:0]           dat;
   } req_t;

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   req_t req_q, req_in, req_cur;
   logic [31:0] dat_q;
   logic req, capture, go_resp;
   logic mis_cur;
   logic [3:0] be;
   logic [31:0] wdata, rd_word, rd_shift, rd_data;
   logic wr_en;
   logic unused_adr;

   logic [31:0] mem [DEPTH];

   assign unused_adr = ^bus.ADR_I[31:ADDR_WIDTH+2];

   assign req = bus.CYC_I & bus.STB_I;

   assign req_in.we  = bus.WE_I;
   assign req_in.sel = bus.SEL_I;
   assign req_in.off = bus.ADR_I[1:0];
   assign req_in.idx = bus.ADR_I[ADDR_WIDTH+1:2];
   assign req_in.dat = bus.DAT_I;

   // Zero wait states resolve in IDLE, before the request is registered.
   assign req_cur = (state_q == IDLE) ? req_in : req_q;

   function automatic logic misaligned(
      input logic [3:0] sel,
      input logic [1:0] off
   );
      logic m;
      unique case (1'b1)
         (sel == 4'b0001): m = 1'b0;
         (sel == 4'b0011): m = (off == 2'd3);
         (sel == 4'b1111): m = (off != 2'd0);
         default:          m = 1'b1;
      endcase
      return m;
   endfunction

   assign mis_cur = misaligned(req_cur.sel, req_cur.off);

   assign be    = req_cur.sel << req_cur.off;
   assign wdata = req_cur.dat << {req_cur.off, 3'b000};

   assign rd_word  = mem[req_cur.idx];
   assign rd_shift = rd_word >> {req_cur.off, 3'b000};

   always_comb begin
      rd_data = 32'd0;
      unique case (1'b1)
         (req_cur.sel == 4'b0001): rd_data = {24'd0, rd_shift[7:0]};
         (req_cur.sel == 4'b0011): rd_data = {16'd0, rd_shift[15:0]};
         default:                  rd_data = rd_shift;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      go_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               capture = 1'b1;
               cnt_d   = WS;
               if (WS == 4'd0) begin
                  state_d = RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!bus.CYC_I) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = RESP;
                  go_resp = 1'b1;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         cnt_q <= 4'd0;
         req_q <= '0;
         dat_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
         if (capture) req_q <= req_in;
         if (go_resp && !req_cur.we)
            dat_q <= mis_cur ? 32'd0 : rd_data;
      end
   end

   // Array has no reset; an edge inside reset must not commit a write.
   assign wr_en = go_resp & req_cur.we & ~mis_cur & RST_N_I;

   always_ff @(posedge CLK_I) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[req_cur.idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   assign bus.DAT_O = dat_q;

`ifdef WB_SRAM_ERR_EN
   logic mis_q;

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I)     mis_q <= 1'b0;
      else if (go_resp) mis_q <= mis_cur;
   end

   assign bus.ACK_O = (state_q == RESP) & ~mis_q;
   assign bus.ERR_O = (state_q == RESP) & mis_q;
`else
   assign bus.ACK_O = (state_q == RESP);
`endif
endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave at WAIT_STATES 1, 3 and 0.
// Expectations for misaligned accesses follow WB_SRAM_ERR_EN.
module tb_wb_sram_slave;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cyc = 1'b0;
   logic stb = 1'b0;
   logic we = 1'b0;
   logic [3:0] sel = 4'b1111;
   logic [31:0] adr = 32'd0;
   logic [31:0] dat = 32'd0;
   int dsel = 0;

   int nvec = 0;
   int nerr = 0;

`ifdef WB_SRAM_ERR_EN
   localparam logic MIS_ACK = 1'b0;
   localparam logic MIS_ERR = 1'b1;
`else
   localparam logic MIS_ACK = 1'b1;
   localparam logic MIS_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   wb_sram_slave_if if0 ();
   wb_sram_slave_if if1 ();
   wb_sram_slave_if if2 ();

   assign if0.CYC_I = cyc && dsel == 0;
   assign if0.STB_I = stb && dsel == 0;
   assign if1.CYC_I = cyc && dsel == 1;
   assign if1.STB_I = stb && dsel == 1;
   assign if2.CYC_I = cyc && dsel == 2;
   assign if2.STB_I = stb && dsel == 2;
   assign if0.WE_I = we;
   assign if1.WE_I = we;
   assign if2.WE_I = we;
   assign if0.SEL_I = sel;
   assign if1.SEL_I = sel;
   assign if2.SEL_I = sel;
   assign if0.ADR_I = adr;
   assign if1.ADR_I = adr;
   assign if2.ADR_I = adr;
   assign if0.DAT_I = dat;
   assign if1.DAT_I = dat;
   assign if2.DAT_I = dat;

   wb_sram_slave #(.ADDR_WIDTH(14), .WAIT_STATES(1)) u_ws1 (
      .CLK_I(clk), .RST_N_I(rst_n), .bus(if0)
   );
   wb_sram_slave #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u_ws3 (
      .CLK_I(clk), .RST_N_I(rst_n), .bus(if1)
   );
   wb_sram_slave #(.ADDR_WIDTH(14), .WAIT_STATES(0)) u_ws0 (
      .CLK_I(clk), .RST_N_I(rst_n), .bus(if2)
   );

   logic ack_m, err_m;
   logic [31:0] dat_m;

   assign ack_m = (dsel == 0) ? if0.ACK_O :
                  (dsel == 1) ? if1.ACK_O : if2.ACK_O;
   assign dat_m = (dsel == 0) ? if0.DAT_O :
                  (dsel == 1) ? if1.DAT_O : if2.DAT_O;
`ifdef WB_SRAM_ERR_EN
   assign err_m = (dsel == 0) ? if0.ERR_O :
                  (dsel == 1) ? if1.ERR_O : if2.ERR_O;
`else
   assign err_m = 1'b0;
`endif

   task automatic check(
      input string tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic bus_op(
      input int d, input logic w, input logic [3:0] s,
      input logic [31:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output logic ak,
      output logic er, output int lat
   );
      @(negedge clk);
      dsel = d; we = w; sel = s; adr = a; dat = wd;
      cyc = 1'b1; stb = 1'b1;
      rd = 32'd0; ak = 1'b0; er = 1'b0; lat = 99;
      @(posedge clk);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack_m || err_m) begin
            ak = ack_m; er = err_m; rd = dat_m; lat = i;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   logic [31:0] rv;
   logic ak, er;
   int lt;
   int nack;
   logic prev;
   logic [31:0] pat [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_ack", {31'd0, ack_m}, 32'd0);
      check("rst_dat", dat_m, 32'd0);

      // reset in the middle of a pending write
      bus_op(1, 1, 4'b1111, 32'h40, 32'h01020304, rv, ak, er, lt);
      check("ws3_wr_ack", {31'd0, ak}, 32'd1);
      bus_op(1, 0, 4'b1111, 32'h40, 32'h0, rv, ak, er, lt);
      check("ws3_rd_dat", rv, 32'h01020304);
      check("ws3_rd_lat", lt, 32'd4);
      @(negedge clk);
      dsel = 1; we = 1'b1; sel = 4'b1111; adr = 32'h40;
      dat = 32'hFFFFFFFF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_ack", {31'd0, ack_m}, 32'd0);
      check("rstmid_dat", dat_m, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus_op(1, 0, 4'b1111, 32'h40, 32'h0, rv, ak, er, lt);
      check("rstmid_old", rv, 32'h01020304);

      // word write/read, one wait state
      bus_op(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, rv, ak, er, lt);
      check("w10_ack", {31'd0, ak}, 32'd1);
      check("w10_lat", lt, 32'd2);
      bus_op(0, 0, 4'b1111, 32'h10, 32'h0, rv, ak, er, lt);
      check("r10_lat", lt, 32'd2);
      check("r10_dat", rv, 32'hDEADBEEF);
      bus_op(0, 1, 4'b1111, 32'h14, 32'h55667788, rv, ak, er, lt);
      check("w14_keepdat", dat_m, 32'hDEADBEEF);

      // byte lanes
      bus_op(0, 1, 4'b1111, 32'h20, 32'h11223344, rv, ak, er, lt);
      bus_op(0, 1, 4'b0001, 32'h22, 32'h000000AA, rv, ak, er, lt);
      check("wb22_ack", {31'd0, ak}, 32'd1);
      bus_op(0, 0, 4'b1111, 32'h20, 32'h0, rv, ak, er, lt);
      check("r20_word", rv, 32'h11AA3344);
      bus_op(0, 0, 4'b0001, 32'h23, 32'h0, rv, ak, er, lt);
      check("r23_byte", rv, 32'h00000011);
      bus_op(0, 0, 4'b0011, 32'h22, 32'h0, rv, ak, er, lt);
      check("r22_half", rv, 32'h000011AA);
      bus_op(0, 0, 4'b0011, 32'h20, 32'h0, rv, ak, er, lt);
      check("r20_half", rv, 32'h00003344);

      // misaligned and illegal accesses
      bus_op(0, 1, 4'b0011, 32'h23, 32'h0000BEEF, rv, ak, er, lt);
      check("mis_w_ack", {31'd0, ak}, {31'd0, MIS_ACK});
      check("mis_w_err", {31'd0, er}, {31'd0, MIS_ERR});
      bus_op(0, 1, 4'b0101, 32'h20, 32'hFFFFFFFF, rv, ak, er, lt);
      check("ill_w_err", {31'd0, er}, {31'd0, MIS_ERR});
      bus_op(0, 0, 4'b1111, 32'h20, 32'h0, rv, ak, er, lt);
      check("mis_unchg", rv, 32'h11AA3344);
      bus_op(0, 0, 4'b1111, 32'h21, 32'h0, rv, ak, er, lt);
      check("mis_r_dat", rv, 32'h0);
      check("mis_r_ack", {31'd0, ak}, {31'd0, MIS_ACK});

      // abort during wait states
      bus_op(1, 1, 4'b1111, 32'h30, 32'hCAFEF00D, rv, ak, er, lt);
      @(negedge clk);
      dsel = 1; we = 1'b1; sel = 4'b1111; adr = 32'h30;
      dat = 32'h0BADBEEF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      nack = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_m || err_m) nack++;
      end
      check("abort_noack", nack, 32'd0);
      bus_op(1, 0, 4'b1111, 32'h30, 32'h0, rv, ak, er, lt);
      check("abort_unchg", rv, 32'hCAFEF00D);
      check("abort_next", lt, 32'd4);

      // held strobe, zero wait states
      for (int i = 0; i < 4; i++) begin
         pat[i] = 32'hC0DE0000 + 32'(i * 17);
         bus_op(2, 1, 4'b1111, 32'(i * 4), pat[i], rv, ak, er, lt);
      end
      check("ws0_lat", lt, 32'd1);
      @(negedge clk);
      dsel = 2; we = 1'b0; sel = 4'b1111; adr = 32'h0;
      cyc = 1'b1; stb = 1'b1;
      nack = 0;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack_m) begin
            check("hold_gap", {31'd0, prev}, 32'd0);
            if (nack < 4) check("hold_dat", dat_m, pat[nack]);
            nack++;
            adr = 32'(nack * 4);
         end
         prev = ack_m;
      end
      cyc = 1'b0; stb = 1'b0;
      check("hold_cnt", nack, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
